// File: rtl/button_debounce.sv
// Pad input conditioner: synchronizer, consecutive-sample debounce filter, clean level and edge pulses.
// Define DEBOUNCE_TOGGLE_EN to add the push-on/push-off toggle_o output.
module button_debounce #(
    parameter int   sync_stages_p     = 2,
    parameter int   debounce_cycles_p = 16,
    parameter logic reset_val_p       = 1'b0
) (
    input  logic clk,
    input  logic reset_i,
    input  logic async_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic toggle_o
`endif
);

    localparam int CntW = (debounce_cycles_p > 1) ? $clog2(debounce_cycles_p) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(debounce_cycles_p - 1);

    if (sync_stages_p < 2 || sync_stages_p > 4) begin : gBadSyncStages
        $error("button_debounce: sync_stages_p must be in 2..4");
    end
    if (debounce_cycles_p < 2 || debounce_cycles_p > 65536) begin : gBadDebounceCycles
        $error("button_debounce: debounce_cycles_p must be in 2..65536");
    end

    logic [sync_stages_p-1:0] r_sync;
    logic [CntW-1:0]          r_cnt;
    logic                     r_stable;
    logic                     r_rise;
    logic                     r_fall;
    logic                     w_syncQ;
    logic                     w_mismatch;
    logic                     w_commit;

    assign w_syncQ    = r_sync[sync_stages_p-1];
    assign w_mismatch = (w_syncQ != r_stable);
    // A commit needs debounce_cycles_p mismatched samples in a row; the last one is this cycle's.
    assign w_commit   = w_mismatch && (r_cnt == CntMax);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_sync   <= {sync_stages_p{reset_val_p}};
            r_cnt    <= '0;
            r_stable <= reset_val_p;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[sync_stages_p-2:0], async_i};
            r_rise <= w_commit && w_syncQ;
            r_fall <= w_commit && !w_syncQ;
            if (!w_mismatch || w_commit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                r_stable <= w_syncQ;
            end
        end
    end

    assign stable_o = r_stable;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign busy_o   = (r_cnt != '0);

`ifdef DEBOUNCE_TOGGLE_EN
    logic r_toggle;

    // Flips once per registered rise pulse, so each clean press inverts the latched state.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_toggle <= 1'b0;
        end else if (r_rise) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign toggle_o = r_toggle;
`endif

endmodule
